// File: rtl/syn_vga_lbffr_fill_if.sv
// Pixel-memory read port: request/ack handshake plus returned-data strobe.
// master = fill engine, slave = memory arbiter.
interface syn_vga_lbffr_fill_if #(
  parameter int P_MEM_ADDR_W = 18
);
  logic                    mem_rd_req;
  logic [P_MEM_ADDR_W-1:0] mem_rd_addr;
  logic                    mem_rd_ack;
  logic                    mem_rd_valid;
  logic [15:0]             mem_rd_data;

  modport master (
    output mem_rd_req, mem_rd_addr,
    input  mem_rd_ack, mem_rd_valid, mem_rd_data
  );

  modport slave (
    input  mem_rd_req, mem_rd_addr,
    output mem_rd_ack, mem_rd_valid, mem_rd_data
  );
endinterface

// File: rtl/syn_vga_lbffr_fill.sv
// Line-buffer fill engine: fetches packed 16-bit frame words once per frame and
// unpacks them into the VGA line-buffer FIFO, throttled by FIFO occupancy.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | driver disabled or test-pattern mode; nothing fetched
//   WAIT_FRM | enabled, waiting for the first vsync falling edge
//   FETCH    | issuing reads for the current frame
//   DRAIN    | all reads issued; waiting for returns and unpack to finish
//   DONE     | frame fully written; waiting for next vsync
module syn_vga_lbffr_fill #(
  parameter int P_HVALID_W   = 640,
  parameter int P_VVALID_W   = 480,
  parameter int P_MEM_ADDR_W = 18,
  parameter int P_FF_DEPTH   = 64,
  parameter int P_FF_OCC_W   = 7,
  parameter int P_MAX_OUTSTD = 4
) (
  input  logic                    clk_ir,
  input  logic                    rst_sync_l,
  input  logic                    vga_drvr_en,
  input  logic                    vga_mode,
  input  logic                    vsync_n,
  input  logic [P_MEM_ADDR_W-1:0] fbuf_base_addr,
  syn_vga_lbffr_fill_if.master    mem,
  output logic                    ff_wr_en,
  output logic [7:0]              ff_wr_data,
  input  logic [P_FF_OCC_W-1:0]   ff_occ,
  output logic                    ff_clr,
  output logic                    fill_underrun
);

  localparam int N_WORDS = P_HVALID_W * P_VVALID_W / 2;
  localparam int WCNT_W  = 18;
  localparam int CNT_W   = $clog2(P_MAX_OUTSTD + 1);
  localparam int DSC_W   = CNT_W + 2;
  localparam int PTR_W   = (P_MAX_OUTSTD > 1) ? $clog2(P_MAX_OUTSTD) : 1;
  localparam int SP_W    = P_FF_OCC_W + CNT_W + 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_FRM = 3'd1,
    S_FETCH    = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                  state, state_nxt;
  logic                    vs_q;
  logic                    go_idle, frm_start, flush, in_fetch, at_rest;
  logic                    req_q, ack_fire, ret_take, pop;
  logic [P_MEM_ADDR_W-1:0] addr_q;
  logic [WCNT_W-1:0]       wcnt;
  logic [CNT_W-1:0]        outst, held;
  logic [CNT_W:0]          inuse;
  logic [SP_W-1:0]         need_occ;
  logic                    issue_ok;
  logic [DSC_W-1:0]        discard, disc_sum, disc_flush;
  logic [15:0]             hold_mem [P_MAX_OUTSTD];
  logic [PTR_W-1:0]        wp, rp;
  logic                    phase;
  logic [15:0]             head;

  assign go_idle   = !vga_drvr_en || vga_mode;
  assign frm_start = vs_q && !vsync_n && !go_idle && (state != S_IDLE);
  assign ack_fire  = req_q && mem.mem_rd_ack && in_fetch;
  assign ret_take  = mem.mem_rd_valid && (discard == '0) && !flush;
  assign pop       = phase && !flush;

  assign mem.mem_rd_req  = req_q;
  assign mem.mem_rd_addr = addr_q;

  // One byte slot is always reserved for a write that ff_occ may not show yet.
  assign inuse    = {1'b0, outst} + {1'b0, held};
  assign need_occ = SP_W'(ff_occ) + SP_W'({inuse, 1'b0}) + SP_W'(2);
  assign issue_ok = (inuse < (CNT_W+1)'(P_MAX_OUTSTD)) &&
                    (need_occ <= SP_W'(P_FF_DEPTH - 1));

  always_ff @(posedge clk_ir) begin
    if (!rst_sync_l) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (go_idle) begin
      state_nxt = S_IDLE;
    end else if (frm_start) begin
      state_nxt = S_FETCH;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_WAIT_FRM;
        S_FETCH: if (ack_fire && (wcnt == WCNT_W'(N_WORDS - 1))) state_nxt = S_DRAIN;
        S_DRAIN: if (at_rest) state_nxt = S_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    flush    = go_idle || frm_start;
    in_fetch = (state == S_FETCH) && !flush;
    at_rest  = (outst == '0) && (held == '0) && !phase;
  end

  // Everything still in flight at a flush, including a same-cycle ack, is owed to the old frame.
  always_comb begin
    disc_sum   = discard + DSC_W'(outst) + DSC_W'(req_q && mem.mem_rd_ack);
    disc_flush = (mem.mem_rd_valid && (disc_sum != '0)) ? disc_sum - 1'b1 : disc_sum;
    head       = (held == '0) ? mem.mem_rd_data : hold_mem[rp];
  end

  always_ff @(posedge clk_ir) begin
    if (ret_take) hold_mem[wp] <= mem.mem_rd_data;
  end

  always_ff @(posedge clk_ir) begin
    if (!rst_sync_l) begin
      vs_q          <= 1'b1;
      ff_clr        <= 1'b0;
      req_q         <= 1'b0;
      addr_q        <= '0;
      wcnt          <= '0;
      outst         <= '0;
      discard       <= '0;
      held          <= '0;
      wp            <= '0;
      rp            <= '0;
      phase         <= 1'b0;
      ff_wr_en      <= 1'b0;
      ff_wr_data    <= '0;
      fill_underrun <= 1'b0;
    end else begin
      vs_q   <= vsync_n;
      ff_clr <= frm_start;

      if (flush)                      req_q <= 1'b0;
      else if (req_q)                 req_q <= !mem.mem_rd_ack;
      else if (in_fetch && issue_ok)  req_q <= 1'b1;

      if (frm_start)     addr_q <= fbuf_base_addr;
      else if (ack_fire) addr_q <= addr_q + 1'b1;

      if (flush)         wcnt <= '0;
      else if (ack_fire) wcnt <= wcnt + 1'b1;

      if (flush) begin
        outst   <= '0;
        discard <= disc_flush;
      end else begin
        outst <= outst + CNT_W'(ack_fire) - CNT_W'(ret_take);
        if (mem.mem_rd_valid && (discard != '0)) discard <= discard - 1'b1;
      end

      if (flush) begin
        held <= '0;
        wp   <= '0;
        rp   <= '0;
      end else begin
        held <= held + CNT_W'(ret_take) - CNT_W'(pop);
        if (ret_take) wp <= (wp == PTR_W'(P_MAX_OUTSTD - 1)) ? '0 : wp + 1'b1;
        if (pop)      rp <= (rp == PTR_W'(P_MAX_OUTSTD - 1)) ? '0 : rp + 1'b1;
      end

      // Low byte may bypass straight from the return bus when nothing is held.
      if (flush) begin
        phase    <= 1'b0;
        ff_wr_en <= 1'b0;
      end else if (phase) begin
        phase      <= 1'b0;
        ff_wr_en   <= 1'b1;
        ff_wr_data <= hold_mem[rp][15:8];
      end else if ((held != '0) || ret_take) begin
        phase      <= 1'b1;
        ff_wr_en   <= 1'b1;
        ff_wr_data <= head[7:0];
      end else begin
        ff_wr_en <= 1'b0;
      end

      if (frm_start)
        fill_underrun <= 1'b0;
      else if ((state == S_FETCH) && (wcnt != '0) && (ff_occ == '0))
        fill_underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_syn_vga_lbffr_fill.sv
// Scoreboard bench for the line-buffer fill engine on a reduced 8x4 frame
// (16 words, 32 bytes) with a zero-wait memory and a 1-byte/2-clk FIFO drain.
module tb_syn_vga_lbffr_fill;
  localparam int AW = 18;
  localparam int OW = 7;
  localparam int HW = 8;
  localparam int VW = 4;
  localparam int NW = HW * VW / 2;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          en = 1'b1;
  logic          mode = 1'b0;
  logic          vsync_n = 1'b1;
  logic [AW-1:0] base = 18'h00100;
  logic          ff_wr_en, ff_clr, underrun;
  logic [7:0]    ff_wr_data;
  logic [OW-1:0] ff_occ;

  syn_vga_lbffr_fill_if #(.P_MEM_ADDR_W(AW)) mif ();

  syn_vga_lbffr_fill #(
    .P_HVALID_W(HW), .P_VVALID_W(VW), .P_MEM_ADDR_W(AW),
    .P_FF_DEPTH(64), .P_FF_OCC_W(OW), .P_MAX_OUTSTD(4)
  ) dut (
    .clk_ir(clk), .rst_sync_l(rst_l), .vga_drvr_en(en), .vga_mode(mode),
    .vsync_n(vsync_n), .fbuf_base_addr(base), .mem(mif.master),
    .ff_wr_en(ff_wr_en), .ff_wr_data(ff_wr_data), .ff_occ(ff_occ),
    .ff_clr(ff_clr), .fill_underrun(underrun)
  );

  always #5 clk = ~clk;

  int            total = 0, bad = 0;
  int            wr_cnt = 0, ack_cnt = 0, req_hi = 0, max_occ = 0, occ = 0;
  logic [7:0]    exp_q[$];
  logic [AW-1:0] pend_q[$];
  logic [AW-1:0] last_addr = '0;
  logic          ack_en = 1'b1, ret_en = 1'b1, occ_force = 1'b0, drain_tog = 1'b0;
  logic [OW-1:0] force_val = '0;

  assign ff_occ = occ_force ? force_val : OW'(occ);

  function automatic logic [15:0] word_of(input logic [AW-1:0] a);
    logic [AW:0] t;
    logic [7:0]  lo, hi;
    t  = {a, 1'b0};
    lo = t[7:0] + 8'd1;
    hi = t[7:0] + 8'd2;
    return {hi, lo};
  endfunction

  task automatic push_frame(input logic [AW-1:0] b);
    logic [15:0] w;
    for (int k = 0; k < NW; k++) begin
      w = word_of(b + AW'(k));
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if (dut.state == 3'd4) break;
      @(negedge clk);
    end
    chk(nm, 32'(dut.state), 32'd4);
  endtask

  task automatic wait_wr(input int n, input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if (wr_cnt >= n) break;
      @(negedge clk);
    end
    chk(nm, 32'(wr_cnt >= n), 32'd1);
  endtask

  // Memory: acks a visible request, returns data one cycle after the ack.
  always @(negedge clk) begin
    logic [AW-1:0] a;
    mif.mem_rd_ack = mif.mem_rd_req && ack_en;
    if (ret_en && pend_q.size() > 0) begin
      a = pend_q.pop_front();
      mif.mem_rd_valid = 1'b1;
      mif.mem_rd_data  = word_of(a);
    end else begin
      mif.mem_rd_valid = 1'b0;
      mif.mem_rd_data  = 16'h0000;
    end
  end

  always @(posedge clk) begin
    if (rst_l && mif.mem_rd_req && mif.mem_rd_ack) begin
      pend_q.push_back(mif.mem_rd_addr);
      last_addr = mif.mem_rd_addr;
      ack_cnt++;
    end
  end

  // Line-buffer FIFO occupancy model.
  always @(posedge clk) begin
    if (!rst_l || ff_clr) occ <= 0;
    else occ <= occ + (ff_wr_en ? 1 : 0) - ((drain_tog && occ > 0) ? 1 : 0);
    drain_tog <= ~drain_tog;
    if (occ > max_occ) max_occ <= occ;
  end

  // Monitor: every FIFO write is matched against the expected byte stream.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_l && mif.mem_rd_req) req_hi++;
    if (rst_l && ff_wr_en) begin
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected act=%02h req=none", ff_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (ff_wr_data !== e) begin
          bad++;
          $display("FAIL wr_data act=%02h req=%02h", ff_wr_data, e);
        end
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_req",   32'(mif.mem_rd_req),  32'd0);
    chk("rst_addr",  32'(mif.mem_rd_addr), 32'd0);
    chk("rst_wr_en", 32'(ff_wr_en),        32'd0);
    chk("rst_wr_dt", 32'(ff_wr_data),      32'd0);
    chk("rst_clr",   32'(ff_clr),          32'd0);
    chk("rst_undr",  32'(underrun),        32'd0);
    chk("rst_state", 32'(dut.state),       32'd0);
    rst_l = 1'b1;
    tick(3);
    chk("wait_frm", 32'(dut.state), 32'd1);

    // Frame 1: full in-order frame from base 0x100.
    push_frame(18'h00100);
    wr_cnt = 0;
    base = 18'h00100; vsync_n = 1'b0;
    tick(1);
    chk("fs_clr",    32'(ff_clr),         32'd1);
    chk("fs_req_lo", 32'(mif.mem_rd_req), 32'd0);
    vsync_n = 1'b1;
    tick(1);
    chk("clr_pulse",  32'(ff_clr),          32'd0);
    chk("first_req",  32'(mif.mem_rd_req),  32'd1);
    chk("first_addr", 32'(mif.mem_rd_addr), 32'h00100);
    wait_done(2000, "f1_done");
    chk("f1_writes",    32'(wr_cnt),       32'(2 * NW));
    chk("f1_last_addr", 32'(last_addr),    32'h0010F);
    chk("f1_q_empty",   32'(exp_q.size()), 32'd0);

    // Occupancy throttle, memory holding all returns.
    ret_en = 1'b0; occ_force = 1'b1; force_val = 7'd62;
    base = 18'h00200; vsync_n = 1'b0;
    tick(1);
    vsync_n = 1'b1;
    req_hi = 0; ack_cnt = 0;
    tick(20);
    chk("thr62_req", 32'(req_hi), 32'd0);
    force_val = 7'd60;
    tick(20);
    chk("thr60_acks", 32'(ack_cnt), 32'd1);
    force_val = 7'd56;
    tick(20);
    chk("thr56_acks", 32'(ack_cnt), 32'd3);
    chk("thr_undr",   32'(underrun), 32'd0);

    // Frame start with 3 reads in flight: their data must be dropped.
    push_frame(18'h00340);
    wr_cnt = 0;
    base = 18'h00340; vsync_n = 1'b0;
    tick(1);
    vsync_n = 1'b1; occ_force = 1'b0; ret_en = 1'b1;
    wait_done(2000, "drop_done");
    chk("drop_writes",  32'(wr_cnt),       32'(2 * NW));
    chk("drop_q_empty", 32'(exp_q.size()), 32'd0);

    // Test-pattern mode mid-fetch: abort, no writes from late returns.
    push_frame(18'h00100);
    wr_cnt = 0;
    base = 18'h00100; vsync_n = 1'b0;
    tick(1);
    vsync_n = 1'b1;
    wait_wr(10, 400, "mode_pre");
    ret_en = 1'b0;
    tick(3);
    mode = 1'b1;
    #1;
    exp_q.delete();
    wr_cnt = 0;
    @(negedge clk);
    chk("mode_req",   32'(mif.mem_rd_req), 32'd0);
    chk("mode_state", 32'(dut.state),      32'd0);
    ret_en = 1'b1;
    tick(20);
    chk("mode_writes", 32'(wr_cnt), 32'd0);
    mode = 1'b0;
    tick(3);
    chk("mode_rearm", 32'(dut.state), 32'd1);

    // Memory stall starves the line buffer.
    push_frame(18'h00100);
    wr_cnt = 0;
    base = 18'h00100; vsync_n = 1'b0;
    tick(1);
    vsync_n = 1'b1;
    wait_wr(8, 400, "ur_pre");
    ack_en = 1'b0;
    tick(200);
    chk("ur_set", 32'(underrun), 32'd1);
    ack_en = 1'b1;
    wait_done(2000, "ur_done");
    chk("ur_sticky", 32'(underrun), 32'd1);
    chk("ur_writes", 32'(wr_cnt),   32'(2 * NW));

    // Next frame start clears the sticky flag.
    push_frame(18'h00100);
    base = 18'h00100; vsync_n = 1'b0;
    tick(1);
    chk("ur_clear", 32'(underrun), 32'd0);
    vsync_n = 1'b1;
    wait_done(2000, "last_done");
    chk("last_q_empty", 32'(exp_q.size()), 32'd0);
    chk("occ_bound",    32'(max_occ <= 64), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
